// File: rtl/alzette_seq.sv
// alzette_seq: multi-cycle sequencer that drives a shared ARX unit
// (a op ror(b, n), op in {add, sub, xor}) through 3 steps per round
// to evaluate the Alzette ARX-box on one (x, y, c) triple.
//
// Optional feature macro: ALZETTE_SEQ_INV_EN
//   defined   -> in_inv port added; in_inv=1 runs the inverse box
//   undefined -> forward direction only, no subtract path
//
// state | meaning
// IDLE  | ready for a triple; in_ready=1
// RUN   | one ARX step per cycle, 3*ROUNDS steps; busy=1
// DONE  | result held on out_x/out_y until out_ready

module alzette_seq #(
    parameter int ROUNDS = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_c,
`ifdef ALZETTE_SEQ_INV_EN
    input  logic        in_inv,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        busy
);

    localparam logic [3:0] LAST_STEP = 4'(3 * ROUNDS - 1);
    localparam logic [1:0] LAST_RND  = 2'(ROUNDS - 1);

    localparam logic [1:0] OP_XOR = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [31:0] c_q;
    logic [31:0] out_x_q;
    logic [31:0] out_y_q;
    logic [3:0]  step_q;
    logic [1:0]  sub_q;
    logic [1:0]  round_q;
    logic        last_step;

    logic [1:0]  rnd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rot_amt;
    logic [1:0]  op_sel;
    logic        wr_x;
    logic [31:0] op_b_rot;
    logic [31:0] result;

`ifdef ALZETTE_SEQ_INV_EN
    logic        inv_q;
`endif

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        // n=0 makes the left shift 32 wide, which yields 0 -> identity
        return (v >> n) | (v << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [4:0] rot_a(input logic [1:0] r);
        case (r)
            2'd0:    return 5'd31;
            2'd1:    return 5'd17;
            2'd2:    return 5'd0;
            default: return 5'd24;
        endcase
    endfunction

    function automatic logic [4:0] rot_b(input logic [1:0] r);
        case (r)
            2'd0:    return 5'd24;
            2'd1:    return 5'd17;
            2'd2:    return 5'd31;
            default: return 5'd16;
        endcase
    endfunction

    assign last_step = (step_q == LAST_STEP);

    // State register
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand, rotation and op selection for the current step
    always_comb begin
        rnd     = round_q;
        op_a    = x_q;
        op_b    = y_q;
        rot_amt = 5'd0;
        op_sel  = OP_XOR;
        wr_x    = 1'b1;
`ifdef ALZETTE_SEQ_INV_EN
        if (inv_q) begin
            // inverse walks the rounds from last to first
            rnd = LAST_RND - round_q;
            case (sub_q)
                2'd0: begin
                    op_a    = x_q;
                    op_b    = c_q;
                    rot_amt = 5'd0;
                    op_sel  = OP_XOR;
                    wr_x    = 1'b1;
                end
                2'd1: begin
                    op_a    = y_q;
                    op_b    = x_q;
                    rot_amt = rot_b(rnd);
                    op_sel  = OP_XOR;
                    wr_x    = 1'b0;
                end
                default: begin
                    op_a    = x_q;
                    op_b    = y_q;
                    rot_amt = rot_a(rnd);
                    op_sel  = OP_SUB;
                    wr_x    = 1'b1;
                end
            endcase
        end else begin
`endif
            case (sub_q)
                2'd0: begin
                    op_a    = x_q;
                    op_b    = y_q;
                    rot_amt = rot_a(rnd);
                    op_sel  = OP_ADD;
                    wr_x    = 1'b1;
                end
                2'd1: begin
                    op_a    = y_q;
                    op_b    = x_q;
                    rot_amt = rot_b(rnd);
                    op_sel  = OP_XOR;
                    wr_x    = 1'b0;
                end
                default: begin
                    op_a    = x_q;
                    op_b    = c_q;
                    rot_amt = 5'd0;
                    op_sel  = OP_XOR;
                    wr_x    = 1'b1;
                end
            endcase
`ifdef ALZETTE_SEQ_INV_EN
        end
`endif
    end

    // Shared rotate + add/sub/xor unit
    always_comb begin
        op_b_rot = ror32(op_b, rot_amt);
        case (op_sel)
            OP_ADD:  result = op_a + op_b_rot;
`ifdef ALZETTE_SEQ_INV_EN
            OP_SUB:  result = op_a - op_b_rot;
`endif
            default: result = op_a ^ op_b_rot;
        endcase
    end

    // Working registers, step counters and the held result
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            c_q     <= 32'd0;
            step_q  <= 4'd0;
            sub_q   <= 2'd0;
            round_q <= 2'd0;
            out_x_q <= 32'd0;
            out_y_q <= 32'd0;
`ifdef ALZETTE_SEQ_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        y_q     <= in_y;
                        c_q     <= in_c;
                        step_q  <= 4'd0;
                        sub_q   <= 2'd0;
                        round_q <= 2'd0;
`ifdef ALZETTE_SEQ_INV_EN
                        inv_q   <= in_inv;
`endif
                    end
                end
                ST_RUN: begin
                    if (wr_x) begin
                        x_q <= result;
                    end else begin
                        y_q <= result;
                    end
                    if (last_step) begin
                        // result registers only move on entry to DONE
                        out_x_q <= wr_x ? result : x_q;
                        out_y_q <= wr_x ? y_q : result;
                    end else begin
                        step_q <= step_q + 4'd1;
                        if (sub_q == 2'd2) begin
                            sub_q   <= 2'd0;
                            round_q <= round_q + 2'd1;
                        end else begin
                            sub_q <= sub_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_x = out_x_q;
    assign out_y = out_y_q;

endmodule
